// File: rtl/stopwatch_ctrl.sv
//------------------------------------------------------------------------------
// Module   : stopwatch_ctrl
// Brief    : Tick dividers, input synchronisers, pause toggle and mode FSM for
//            the stopwatch; optional PAUSE debounce via `CTRL_DEBOUNCE_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stopwatch_ctrl #(
  parameter int DIV_HALF   = 50_000_000,
  parameter int DIV_SCAN   = 200_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       RESET,
  input  logic       PAUSE,
  input  logic       ADJ,
  input  logic       SEL,
  output logic [1:0] mode,
  output logic       paused,
  output logic       cnt_tick,
  output logic       tick_2hz,
  output logic       tick_1hz,
  output logic       tick_scan,
  output logic       blink
);

  localparam int c_half_w = (DIV_HALF > 1) ? $clog2(DIV_HALF) : 1;
  localparam int c_scan_w = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;
  localparam logic [c_half_w-1:0] c_half_last = c_half_w'(DIV_HALF - 1);
  localparam logic [c_scan_w-1:0] c_scan_last = c_scan_w'(DIV_SCAN - 1);

  typedef enum logic [1:0] {
    ST_BASIC   = 2'd0,
    ST_ADJ_MIN = 2'd1,
    ST_ADJ_SEC = 2'd2
  } state_t;

  if (DIV_HALF < 1 || DIV_SCAN < 1 || DEB_CYCLES < 1) begin : g_param_check
    $error("stopwatch_ctrl: divisors and DEB_CYCLES must be >= 1");
  end

  logic [c_half_w-1:0] r_half_cnt;
  logic [c_scan_w-1:0] r_scan_cnt;
  logic                r_phase;
  logic                w_tick_2hz;
  logic                w_tick_scan;

  assign w_tick_2hz  = (r_half_cnt == c_half_last);
  assign w_tick_scan = (r_scan_cnt == c_scan_last);

  // r_phase doubles as the blink phase: both toggle on every half-second tick.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_half_cnt <= '0;
      r_phase    <= 1'b0;
    end else if (w_tick_2hz) begin
      r_half_cnt <= '0;
      r_phase    <= ~r_phase;
    end else begin
      r_half_cnt <= r_half_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_scan_cnt <= '0;
    end else if (w_tick_scan) begin
      r_scan_cnt <= '0;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  // Bit order: {SEL, ADJ, PAUSE}
  logic [2:0] r_sync_meta;
  logic [2:0] r_sync;

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_sync_meta <= '0;
      r_sync      <= '0;
    end else begin
      r_sync_meta <= {SEL, ADJ, PAUSE};
      r_sync      <= r_sync_meta;
    end
  end

  logic w_pause_sync;
  logic w_adj_sync;
  logic w_sel_sync;
  logic w_pause_acc;

  assign w_pause_sync = r_sync[0];
  assign w_adj_sync   = r_sync[1];
  assign w_sel_sync   = r_sync[2];

`ifdef CTRL_DEBOUNCE_EN
  localparam int c_deb_w = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [c_deb_w-1:0] c_deb_last = c_deb_w'(DEB_CYCLES - 1);

  logic [c_deb_w-1:0] r_deb_cnt;
  logic               r_pause_acc;

  // Any cycle where the input agrees with the accepted level restarts the count.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_deb_cnt   <= '0;
      r_pause_acc <= 1'b0;
    end else if (w_pause_sync == r_pause_acc) begin
      r_deb_cnt   <= '0;
    end else if (r_deb_cnt == c_deb_last) begin
      r_deb_cnt   <= '0;
      r_pause_acc <= w_pause_sync;
    end else begin
      r_deb_cnt   <= r_deb_cnt + 1'b1;
    end
  end

  assign w_pause_acc = r_pause_acc;
`else
  assign w_pause_acc = w_pause_sync;
`endif

  logic r_pause_prev;
  logic r_paused;

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_pause_prev <= 1'b0;
      r_paused     <= 1'b0;
    end else begin
      r_pause_prev <= w_pause_acc;
      if (w_pause_acc && !r_pause_prev) begin
        r_paused <= ~r_paused;
      end
    end
  end

  state_t r_state;
  state_t w_state_nxt;
  logic   w_cnt_tick;

  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state <= ST_BASIC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Count source follows the registered state, so a mode change takes effect
  // from the cycle the mode output changes.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_tick  = 1'b0;
    if (!w_adj_sync) begin
      w_state_nxt = ST_BASIC;
    end else if (w_sel_sync) begin
      w_state_nxt = ST_ADJ_SEC;
    end else begin
      w_state_nxt = ST_ADJ_MIN;
    end
    case (r_state)
      ST_BASIC:   w_cnt_tick = w_tick_2hz & r_phase & ~r_paused;
      ST_ADJ_MIN,
      ST_ADJ_SEC: w_cnt_tick = w_tick_2hz & ~r_paused;
      default:    w_cnt_tick = 1'b0;
    endcase
  end

  assign mode      = r_state;
  assign paused    = r_paused;
  assign cnt_tick  = w_cnt_tick;
  assign tick_2hz  = w_tick_2hz;
  assign tick_1hz  = w_tick_2hz & r_phase;
  assign tick_scan = w_tick_scan;
  assign blink     = r_phase;

endmodule

`default_nettype wire
